// File: rtl/mem_bus_unit_if.sv
// Memory-stage bundle for mem_bus_unit: the pipeline-side request and result,
// plus the byte-serial beat bus toward memory.
interface mem_bus_unit_if;
   logic [3:0]  op_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        stallreq_from_mem;
   logic [31:0] rdata_o;
   logic        done_o;
   logic        bus_err_o;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_baddr;
   logic [7:0]  mem_bwdata;
   logic [7:0]  mem_brdata;
   logic        mem_ack;

   modport master (
      input  op_i, addr_i, wdata_i, mem_brdata, mem_ack,
      output stallreq_from_mem, rdata_o, done_o, bus_err_o,
      output mem_req, mem_we, mem_baddr, mem_bwdata
   );

   modport slave (
      output op_i, addr_i, wdata_i, mem_brdata, mem_ack,
      input  stallreq_from_mem, rdata_o, done_o, bus_err_o,
      input  mem_req, mem_we, mem_baddr, mem_bwdata
   );
endinterface

// File: rtl/mem_bus_unit.sv
// Byte-serial load/store unit for the MEM stage, with a per-beat ack timeout.
// Optional macro MEM_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into bus errors.
module mem_bus_unit #(
   parameter int ACK_TIMEOUT = 16
) (
   input logic            CLK,
   input logic            RST_N,
   mem_bus_unit_if.master bus
);
   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LW  = 4'd3;
   localparam logic [3:0] OP_LBU = 4'd4;
   localparam logic [3:0] OP_LHU = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   localparam int WW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t            state_q, state_d;
   logic [3:0]        op_q, op_d;
   logic [2:0]        idx_q, idx_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [WW-1:0]     wait_q, wait_d;
   logic [3:0][7:0]   buf_q, buf_d;
   logic              err_q, err_d;
   logic [31:0]       rdata_q, rdata_d;

   logic              op_valid;
   logic [2:0]        op_beats;
   logic              misalign;
   logic              xfer;
   logic              last_beat;
   logic [3:0][7:0]   wbytes;

   function automatic logic [31:0] extend(input logic [3:0] op, input logic [31:0] w);
      case (op)
         OP_LB:   return {{24{w[7]}}, w[7:0]};
         OP_LH:   return {{16{w[15]}}, w[15:0]};
         OP_LBU:  return {24'd0, w[7:0]};
         OP_LHU:  return {16'd0, w[15:0]};
         default: return w;
      endcase
   endfunction

   assign op_valid = (bus.op_i >= OP_LB) && (bus.op_i <= OP_SW);

   always_comb begin
      op_beats = 3'd4;
      if (bus.op_i == OP_LB || bus.op_i == OP_LBU || bus.op_i == OP_SB)
         op_beats = 3'd1;
      else if (bus.op_i == OP_LH || bus.op_i == OP_LHU || bus.op_i == OP_SH)
         op_beats = 3'd2;
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_comb begin
      misalign = 1'b0;
      if (op_beats == 3'd2)
         misalign = bus.addr_i[0];
      else if (op_beats == 3'd4)
         misalign = (bus.addr_i[1:0] != 2'b00);
   end
`else
   assign misalign = 1'b0;
`endif

   assign xfer      = (state_q == XFER);
   assign last_beat = ((idx_q + 3'd1) == cnt_q);
   assign wbytes    = bus.wdata_i;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      wait_d  = wait_q;
      buf_d   = buf_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (op_valid) begin
               op_d    = bus.op_i;
               cnt_d   = op_beats;
               idx_d   = 3'd0;
               wait_d  = '0;
               err_d   = misalign;
               state_d = misalign ? DONE : XFER;
            end
         end
         XFER: begin
            // An ack on the final wait cycle still wins over the timeout.
            if (bus.mem_ack) begin
               buf_d[idx_q[1:0]] = bus.mem_brdata;
               wait_d = '0;
               if (last_beat) begin
                  state_d = DONE;
                  err_d   = 1'b0;
                  if (op_q <= OP_LHU)
                     rdata_d = extend(op_q, buf_d);
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else if (wait_q == WAIT_LAST) begin
               state_d = DONE;
               err_d   = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         op_q    <= 4'd0;
         idx_q   <= 3'd0;
         cnt_q   <= 3'd0;
         wait_q  <= '0;
         buf_q   <= '0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
         buf_q   <= buf_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Stall is gated by RST_N so it falls together with the asynchronous reset.
   assign bus.stallreq_from_mem = RST_N & ((state_q == IDLE && op_valid) || xfer);
   assign bus.mem_req    = xfer;
   assign bus.mem_we     = xfer && (op_q >= OP_SB) && (op_q <= OP_SW);
   assign bus.mem_baddr  = xfer ? (bus.addr_i + {29'd0, idx_q}) : 32'd0;
   assign bus.mem_bwdata = xfer ? wbytes[idx_q[1:0]] : 8'd0;
   assign bus.done_o     = (state_q == DONE) && !err_q;
   assign bus.bus_err_o  = (state_q == DONE) && err_q;
   assign bus.rdata_o    = rdata_q;
endmodule

// File: tb/tb_mem_bus_unit.sv
// Scoreboard bench for mem_bus_unit: expected beats/results queued at issue, checked as the DUT responds.
module tb_mem_bus_unit;
   localparam int TO = 16;
   localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
                          OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;

   mem_bus_unit_if bus();

   mem_bus_unit #(.ACK_TIMEOUT(TO)) dut (
      .CLK  (CLK),
      .RST_N(RST_N),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [7:0]  wd;
   } beat_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          stall;
   } res_t;

   beat_t beat_q[$];
   res_t  res_q[$];
   logic [7:0] mem [logic [31:0]];
   int n_checks = 0;
   int n_fail = 0;
   logic [31:0] last_rdata = 32'd0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a[7:0] ^ 8'h5A;
   endfunction

   // Caller must be at a negedge; returns at a negedge.
   task automatic do_op(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input int dly);
      int n, stall_cnt, bw;
      logic st, mis, seen;
      logic [31:0] w;
      beat_t bt;
      res_t r;
      n  = (op == OP_LB || op == OP_LBU || op == OP_SB) ? 1 :
           (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 4;
      st = (op >= OP_SB);
      mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      if (n == 2) mis = addr[0];
      if (n == 4) mis = (addr[1:0] != 2'b00);
`endif
      w = 32'd0;
      for (int i = 0; i < n; i++) begin
         bt.addr = addr + i;
         bt.we   = st;
         bt.wd   = wd[8*i +: 8];
         beat_q.push_back(bt);
         w[8*i +: 8] = mem_rd(addr + i);
      end
      r.err = 1'b0;
      if (mis) begin
         r.err = 1'b1; r.stall = 1; beat_q.delete();
      end else if (dly >= TO) begin
         r.err = 1'b1; r.stall = 1 + TO;
      end else begin
         r.stall = 1 + n * (dly + 1);
      end
      if (r.err || st) r.rdata = last_rdata;
      else case (op)
         OP_LB:   r.rdata = {{24{w[7]}}, w[7:0]};
         OP_LH:   r.rdata = {{16{w[15]}}, w[15:0]};
         OP_LBU:  r.rdata = {24'd0, w[7:0]};
         OP_LHU:  r.rdata = {16'd0, w[15:0]};
         default: r.rdata = w;
      endcase
      last_rdata = r.rdata;
      res_q.push_back(r);

      bus.op_i = op; bus.addr_i = addr; bus.wdata_i = wd;
      stall_cnt = 0; bw = 0; seen = 1'b0;
      for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
         #1;
         bus.mem_ack = 1'b0;
         if (bus.done_o || bus.bus_err_o) begin
            seen = 1'b1;
            r = res_q.pop_front();
            check_eq("stall_in_done", {31'd0, bus.stallreq_from_mem}, 32'd0);
            check_eq("done_o", {31'd0, bus.done_o}, {31'd0, !r.err});
            check_eq("bus_err_o", {31'd0, bus.bus_err_o}, {31'd0, r.err});
            check_eq("rdata_o", bus.rdata_o, r.rdata);
            check_eq("stall_cycles", stall_cnt, r.stall);
            if (!r.err) check_eq("beats_left", beat_q.size(), 32'd0);
            beat_q.delete();
            bus.op_i = 4'd0;
            $display("op=%0d addr=%h wdata=%h dly=%0d -> rdata=%h done=%0b err=%0b stall=%0d",
                     op, addr, wd, dly, bus.rdata_o, bus.done_o, bus.bus_err_o, stall_cnt);
         end else begin
            if (bus.stallreq_from_mem) stall_cnt++;
            if (bus.mem_req) begin
               if (beat_q.size() == 0) begin
                  check_eq("beat_expected", beat_q.size(), 32'd1);
               end else begin
                  check_eq("mem_baddr", bus.mem_baddr, beat_q[0].addr);
                  check_eq("mem_we", {31'd0, bus.mem_we}, {31'd0, beat_q[0].we});
                  if (beat_q[0].we) check_eq("mem_bwdata", {24'd0, bus.mem_bwdata}, {24'd0, beat_q[0].wd});
                  if (bw == dly) begin
                     bus.mem_ack = 1'b1;
                     bus.mem_brdata = mem_rd(bus.mem_baddr);
                     if (beat_q[0].we) mem[bus.mem_baddr] = bus.mem_bwdata;
                     void'(beat_q.pop_front());
                     bw = 0;
                  end else begin
                     bw++;
                  end
               end
            end
            @(negedge CLK);
         end
      end
      if (!seen) begin
         check_eq("completion", {31'd0, seen}, 32'd1);
         res_q.delete(); beat_q.delete();
         bus.op_i = 4'd0; bus.mem_ack = 1'b0;
      end
      @(negedge CLK);
   endtask

   task automatic check_outputs_zero(input string tag, input logic [31:0] exp_rdata);
      check_eq({tag, "_stall"}, {31'd0, bus.stallreq_from_mem}, 32'd0);
      check_eq({tag, "_req"}, {31'd0, bus.mem_req}, 32'd0);
      check_eq({tag, "_we"}, {31'd0, bus.mem_we}, 32'd0);
      check_eq({tag, "_done"}, {31'd0, bus.done_o}, 32'd0);
      check_eq({tag, "_err"}, {31'd0, bus.bus_err_o}, 32'd0);
      check_eq({tag, "_baddr"}, bus.mem_baddr, 32'd0);
      check_eq({tag, "_bwdata"}, {24'd0, bus.mem_bwdata}, 32'd0);
      check_eq({tag, "_rdata"}, bus.rdata_o, exp_rdata);
   endtask

   initial begin
      logic found;
      bus.op_i = 4'd0; bus.addr_i = 32'd0; bus.wdata_i = 32'd0;
      bus.mem_ack = 1'b0; bus.mem_brdata = 8'd0;
      mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
      mem[32'h20] = 8'h80; mem[32'h30] = 8'h34; mem[32'h31] = 8'hF2;

      repeat (3) @(negedge CLK);
      #1 check_outputs_zero("reset", 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      do_op(OP_LW, 32'h100, 32'd0, 0);
      do_op(OP_LB, 32'h20, 32'd0, 0);
      do_op(OP_LBU, 32'h20, 32'd0, 0);
      do_op(OP_SH, 32'h40, 32'hAABBCCDD, 3);

      bus.op_i = 4'hC; bus.mem_ack = 1'b1; bus.mem_brdata = 8'hFF;
      #1 check_outputs_zero("idle_op12", last_rdata);
      @(negedge CLK);
      #1 check_outputs_zero("idle_ack", last_rdata);
      bus.op_i = 4'd0; bus.mem_ack = 1'b0;
      @(negedge CLK);

      do_op(OP_LW, 32'h200, 32'd0, 255);
      do_op(OP_LB, 32'h21, 32'd0, TO - 1);
      do_op(OP_LH, 32'h30, 32'd0, 1);
      do_op(OP_LHU, 32'h30, 32'd0, 0);
      do_op(OP_SW, 32'h50, 32'hCAFEBABE, 0);
      do_op(OP_SB, 32'h51, 32'h000000A5, 2);
      do_op(OP_LW, 32'h50, 32'd0, 0);
      do_op(OP_LW, 32'h102, 32'd0, 0);
      do_op(OP_LH, 32'hFFFFFFFF, 32'd0, 0);

      bus.op_i = OP_SW; bus.addr_i = 32'h80; bus.wdata_i = 32'h11223344;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         #1;
         bus.mem_ack = 1'b0;
         if (bus.mem_req && bus.mem_baddr == 32'h81) found = 1'b1;
         else begin
            bus.mem_ack = bus.mem_req;
            bus.mem_brdata = 8'h00;
            @(negedge CLK);
         end
      end
      check_eq("reached_beat2", {31'd0, found}, 32'd1);
      #2 RST_N = 1'b0;
      #1 check_outputs_zero("async_reset", 32'd0);
      bus.op_i = 4'd0; bus.mem_ack = 1'b0;
      last_rdata = 32'd0;
      beat_q.delete(); res_q.delete();
      @(negedge CLK);
      RST_N = 1'b1;
      do_op(OP_LB, 32'h20, 32'd0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
